// File: rtl/riscv_crypto_fu_aes32_dec.sv
// ---------------------------------------------------------------------------
// riscv_crypto_fu_aes32_dec
//
// Purpose:
//   Multi-cycle AES decryption helper unit for 32-bit RISC-V crypto ops.
//   A single 8-bit AES inverse S-box is time-shared, one byte per cycle.
//     in_op 00 DSI        : rd = rs1 ^ rol32({24'h0, s}, 8*bs)
//     in_op 01 DSMI       : rd = rs1 ^ rol32({s*0B, s*0D, s*09, s*0E}, 8*bs)
//     in_op 10 INVSUBWORD : rd = InvSbox applied to each byte of rs2
//     in_op 11 IMIX       : rd = InvMixColumns(rs2), byte 0 is row 0
//   where s = InvSbox(rs2[8*bs +: 8]).
//
// Ports:
//   g_clk      in   1   clock, rising edge
//   g_resetn   in   1   synchronous active-low reset
//   flush      in   1   abandon any in-flight operation
//   in_valid   in   1   request valid
//   in_ready   out  1   unit idle and able to accept
//   in_op      in   2   operation select
//   in_bs      in   2   byte select (DSI/DSMI)
//   in_rs1     in  32   accumulator word
//   in_rs2     in  32   source word
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   out_rd     out 32   result word
//
// Parameter:
//   ZERO_WHEN_IDLE  1: out_rd reads zero while out_valid is low
//                   0: out_rd holds the last computed result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// riscv_crypto_aes_inv_sbox
//   Combinational AES inverse S-box: inverse affine map followed by the
//   multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1.
//   data   in  8  input byte
//   result out 8  InvSbox(data)
// ---------------------------------------------------------------------------
module riscv_crypto_aes_inv_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  // GF(2^8) multiply, shift-and-add with reduction by 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    // accumulate a^(2+4+...+128) = a^254
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse of the S-box affine transform: rol1 ^ rol3 ^ rol6 ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  // Inverse S-box lookup
  always_comb begin
    result = gf_inv(inv_affine(data));
  end

endmodule

module riscv_crypto_fu_aes32_dec #(
  parameter bit ZERO_WHEN_IDLE = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [1:0]  in_bs,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd
);

  localparam logic [1:0] OP_DSI  = 2'b00;
  localparam logic [1:0] OP_DSMI = 2'b01;
  localparam logic [1:0] OP_ISW  = 2'b10;
  localparam logic [1:0] OP_IMIX = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  logic [1:0]  op_r;
  logic [1:0]  bs_r;
  logic [1:0]  cnt_r;
  logic [31:0] rs1_r;
  logic [31:0] rs2_r;
  logic [23:0] acc_r;       // INVSUBWORD bytes 0..2; byte 3 goes straight to the result
  logic [7:0]  s_r;         // substituted byte held between SUB and MIX for DSMI
  logic [31:0] res_r;
  logic        out_valid_r;

  logic        in_ready_s;
  logic        accept_s;
  logic        sub_last_s;
  logic        load_res_s;
  logic        clear_res_s;
  logic [1:0]  sel_s;
  logic [7:0]  sbox_in_s;
  logic [7:0]  sbox_out_s;
  logic [31:0] res_next_s;

  // xtime: multiply by 02 in GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Packed inverse-MixColumns coefficients of one byte: {a*0B, a*0D, a*09, a*0E}
  function automatic logic [31:0] mul_set(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a, x8 ^ x4 ^ x2};
  endfunction

  // Rotate a word left by whole bytes
  function automatic logic [31:0] rol_bytes(input logic [31:0] w, input logic [1:0] bs);
    logic [31:0] r;
    case (bs)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[7:0],  w[31:8]};
      default: r = w;
    endcase
    return r;
  endfunction

  // InvMixColumns on one column, byte 0 (bits 7:0) is row 0
  function automatic logic [31:0] inv_mix(input logic [31:0] a);
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m2;
    logic [31:0] m3;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  r3;
    // field layout of mul_set: [31:24]=*0B [23:16]=*0D [15:8]=*09 [7:0]=*0E
    m0 = mul_set(a[7:0]);
    m1 = mul_set(a[15:8]);
    m2 = mul_set(a[23:16]);
    m3 = mul_set(a[31:24]);
    r0 = m0[7:0] ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
    r1 = m1[7:0] ^ m2[31:24] ^ m3[23:16] ^ m0[15:8];
    r2 = m2[7:0] ^ m3[31:24] ^ m0[23:16] ^ m1[15:8];
    r3 = m3[7:0] ^ m0[31:24] ^ m1[23:16] ^ m2[15:8];
    return {r3, r2, r1, r0};
  endfunction

  // The single shared inverse S-box
  riscv_crypto_aes_inv_sbox u_inv_sbox (
    .data   (sbox_in_s),
    .result (sbox_out_s)
  );

  // FSM state register
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; flush returns to IDLE from every state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && !flush) begin
          next_state_s = (in_op == OP_IMIX) ? MIX : SUB;
        end else begin
          next_state_s = IDLE;
        end
      end
      SUB: begin
        if (flush) begin
          next_state_s = IDLE;
        end else if (!sub_last_s) begin
          next_state_s = SUB;
        end else if (op_r == OP_DSMI) begin
          next_state_s = MIX;
        end else begin
          next_state_s = DONE;
        end
      end
      MIX: begin
        if (flush) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: handshake and datapath control strobes
  always_comb begin
    in_ready_s  = (state_r == IDLE);
    accept_s    = in_ready_s && in_valid && !flush;
    // DSI/DSMI substitute one byte; INVSUBWORD walks all four
    sub_last_s  = (op_r != OP_ISW) || (cnt_r == 2'd3);
    sel_s       = (op_r == OP_ISW) ? cnt_r : bs_r;
    load_res_s  = (next_state_s == DONE) && (state_r != DONE);
    clear_res_s = ZERO_WHEN_IDLE && (state_r == DONE) && (next_state_s == IDLE);
  end

  // Select the rs2 byte presented to the shared S-box
  always_comb begin
    case (sel_s)
      2'd0:    sbox_in_s = rs2_r[7:0];
      2'd1:    sbox_in_s = rs2_r[15:8];
      2'd2:    sbox_in_s = rs2_r[23:16];
      2'd3:    sbox_in_s = rs2_r[31:24];
      default: sbox_in_s = rs2_r[7:0];
    endcase
  end

  // Final result word, formed on the edge that enters DONE
  always_comb begin
    res_next_s = res_r;
    case (state_r)
      SUB: begin
        if (op_r == OP_ISW) begin
          res_next_s = {sbox_out_s, acc_r};
        end else begin
          res_next_s = rs1_r ^ rol_bytes({24'h000000, sbox_out_s}, bs_r);
        end
      end
      MIX: begin
        if (op_r == OP_IMIX) begin
          res_next_s = inv_mix(rs2_r);
        end else begin
          res_next_s = rs1_r ^ rol_bytes(mul_set(s_r), bs_r);
        end
      end
      default: res_next_s = res_r;
    endcase
  end

  // Request operands, captured only on accept so later input changes are ignored
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      op_r  <= OP_DSI;
      bs_r  <= 2'd0;
      rs1_r <= 32'h00000000;
      rs2_r <= 32'h00000000;
    end else if (accept_s) begin
      op_r  <= in_op;
      bs_r  <= in_bs;
      rs1_r <= in_rs1;
      rs2_r <= in_rs2;
    end
  end

  // Byte counter for INVSUBWORD; naturally wraps 3 -> 0
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt_r <= 2'd0;
    end else if (accept_s || flush) begin
      cnt_r <= 2'd0;
    end else if ((state_r == SUB) && (op_r == OP_ISW)) begin
      cnt_r <= cnt_r + 2'd1;
    end
  end

  // Partial-result capture during SUB
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      acc_r <= 24'h000000;
      s_r   <= 8'h00;
    end else if (state_r == SUB) begin
      if (op_r == OP_ISW) begin
        case (cnt_r)
          2'd0:    acc_r[7:0]   <= sbox_out_s;
          2'd1:    acc_r[15:8]  <= sbox_out_s;
          2'd2:    acc_r[23:16] <= sbox_out_s;
          default: acc_r        <= acc_r;
        endcase
      end else begin
        s_r <= sbox_out_s;
      end
    end
  end

  // Registered result word and valid flag
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      res_r       <= 32'h00000000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == DONE);
      if (load_res_s) begin
        res_r <= res_next_s;
      end else if (clear_res_s) begin
        res_r <= 32'h00000000;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_rd    = res_r;

endmodule

// File: tb/tb_riscv_crypto_fu_aes32_dec.sv
// ---------------------------------------------------------------------------
// tb_riscv_crypto_fu_aes32_dec
//   Directed vectors with hand-computed results, a latency/handshake model
//   checked every cycle, and a random traffic phase against the same model.
// ---------------------------------------------------------------------------
module tb_riscv_crypto_fu_aes32_dec;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [1:0]  in_bs = 2'd0;
  logic [31:0] in_rs1 = 32'h0;
  logic [31:0] in_rs2 = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd;

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  riscv_crypto_fu_aes32_dec dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_bs     (in_bs),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd)
  );

  // ---------------- reference arithmetic ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // Forward S-box from brute-force inverse plus affine map, then invert the table
  task automatic build_tab();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      inv_tab[s] = x[7:0];
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [1:0] bs,
                                         input logic [31:0] r1, input logic [31:0] r2);
    logic [7:0]  a [4];
    logic [7:0]  s;
    logic [31:0] w;
    logic [31:0] r;
    logic [63:0] d;
    int sh;
    for (int i = 0; i < 4; i++) a[i] = r2[8*i +: 8];
    s  = inv_tab[a[bs]];
    sh = 8 * bs;
    if (op == 2'd2) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = inv_tab[a[i]];
      return r;
    end
    if (op == 2'd3) begin
      for (int i = 0; i < 4; i++)
        r[8*i +: 8] = gm(a[i], 8'h0e) ^ gm(a[(i+1)%4], 8'h0b) ^
                      gm(a[(i+2)%4], 8'h0d) ^ gm(a[(i+3)%4], 8'h09);
      return r;
    end
    if (op == 2'd0) w = {24'h0, s};
    else            w = {gm(s, 8'h0b), gm(s, 8'h0d), gm(s, 8'h09), gm(s, 8'h0e)};
    d = {w, w} >> (32 - sh);
    return r1 ^ d[31:0];
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 1;
    endcase
  endfunction

  // ---------------- cycle-level expectation model ----------------
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt = 0;
  int          m_accepts = 0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] m_rd = 32'h0;
  bit          chk_en = 1'b0;

  always @(posedge g_clk) begin
    if (!g_resetn) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
    end else if (m_valid) begin
      if (flush || out_ready) m_valid = 1'b0;
    end else if (m_busy) begin
      if (flush) m_busy = 1'b0;
      else begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 1'b0; m_valid = 1'b1; m_rd = m_pend; end
      end
    end else if (in_valid && !flush) begin
      m_busy = 1'b1;
      m_cnt = lat_of(in_op);
      m_pend = golden(in_op, in_bs, in_rs1, in_rs2);
      m_accepts++;
    end
  end

  always @(negedge g_clk) begin
    if (chk_en) begin
      logic exp_ready;
      logic [31:0] exp_rd;
      exp_ready = !m_busy && !m_valid;
      exp_rd = m_valid ? m_rd : 32'h0;
      total++;
      if (in_ready !== exp_ready || out_valid !== m_valid || out_rd !== exp_rd) begin
        bad++;
        $display("FAIL cycle_check t=%0t got ready=%b valid=%b rd=%08h want ready=%b valid=%b rd=%08h",
                 $time, in_ready, out_valid, out_rd, exp_ready, m_valid, exp_rd);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk); #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] bs,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] exp_rd, input int exp_lat);
    int n;
    step();
    in_valid = 1'b1; in_op = op; in_bs = bs; in_rs1 = r1; in_rs2 = r2; out_ready = 1'b0;
    step();                                   // accept edge
    in_valid = 1'b0;
    in_op = ~op; in_bs = ~bs; in_rs1 = ~r1; in_rs2 = ~r2;  // must not disturb the result
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 20);
    check({name, "_lat"}, n, exp_lat);
    check({name, "_rd"}, out_rd, exp_rd);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_after"}, {31'h0, out_valid}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    int cyc;
    build_tab();

    // pin the model with hand-computed values
    check("pin_dsi",  golden(2'd0, 2'd0, 32'hFFFFFFFF, 32'h0000007C), 32'hFFFFFFFE);
    check("pin_dsmi", golden(2'd1, 2'd2, 32'h00000000, 32'h00010000), 32'h417E5365);
    check("pin_isw",  golden(2'd2, 2'd0, 32'h12345678, 32'h0063007C), 32'h52005201);
    check("pin_imix", golden(2'd3, 2'd0, 32'hDEADBEEF, 32'hBCA14D8E), 32'h455313DB);

    // reset
    g_resetn = 1'b0;
    repeat (2) step();
    g_resetn = 1'b1;
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_rd", out_rd, 32'h0);
    chk_en = 1'b1;

    // basic operations
    run_op("dsi",     2'd0, 2'd0, 32'hFFFFFFFF, 32'h0000007C, 32'hFFFFFFFE, 1);
    run_op("dsmi",    2'd1, 2'd2, 32'h00000000, 32'h00010000, 32'h417E5365, 2);
    run_op("isw",     2'd2, 2'd0, 32'hCAFEF00D, 32'h0063007C, 32'h52005201, 4);
    run_op("imix",    2'd3, 2'd1, 32'h11111111, 32'hBCA14D8E, 32'h455313DB, 1);
    run_op("dsi_bs3", 2'd0, 2'd3, 32'h00000000, 32'h7C000000, 32'h01000000, 1);

    // backpressure with a waiting request held high
    step();
    in_valid = 1'b1; in_op = 2'd0; in_bs = 2'd0; in_rs1 = 32'h0; in_rs2 = 32'h0000007C;
    step();                                   // accept DSI
    in_op = 2'd3; in_rs2 = 32'hBCA14D8E;       // next request stays asserted
    step();
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    check("bp_rd0", out_rd, 32'h00000001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rd_hold", out_rd, 32'h00000001);
      check("bp_ready_low", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    step();                                   // transfer edge, no accept here
    out_ready = 1'b0;
    check("bp_idle_ready", {31'h0, in_ready}, 32'h1);
    check("bp_idle_valid", {31'h0, out_valid}, 32'h0);
    step();                                   // accept of the held request
    check("bp_accepted", {31'h0, in_ready}, 32'h0);
    in_valid = 1'b0;
    step();
    check("bp_imix_rd", out_rd, 32'h455313DB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // flush during the third SUB cycle of INVSUBWORD
    step();
    in_valid = 1'b1; in_op = 2'd2; in_rs2 = 32'h0063007C;
    step();                                   // accept
    in_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_ready", {31'h0, in_ready}, 32'h1);
    check("fl_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fl_no_valid", {31'h0, out_valid}, 32'h0);
    end
    run_op("fl_dsi", 2'd0, 2'd0, 32'h00000000, 32'h00000063, 32'h00000000, 1);

    // reset in the middle of DSMI
    step();
    in_valid = 1'b1; in_op = 2'd1; in_bs = 2'd2; in_rs1 = 32'h0; in_rs2 = 32'h00010000;
    step();                                   // accept
    in_valid = 1'b0;
    g_resetn = 1'b0;
    step();
    g_resetn = 1'b1;
    check("mr_valid", {31'h0, out_valid}, 32'h0);
    check("mr_ready", {31'h0, in_ready}, 32'h1);
    check("mr_rd", out_rd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_no_valid", {31'h0, out_valid}, 32'h0);
    end

    // random traffic against the model
    start = m_accepts;
    cyc = 0;
    while ((m_accepts - start) < 10000 && cyc < 90000) begin
      step();
      in_valid  = ($urandom_range(9) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(63) == 0);
      in_op     = 2'($urandom_range(3));
      in_bs     = 2'($urandom_range(3));
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      cyc++;
    end
    check("rand_ops", m_accepts - start, 10000);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
